// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequencing controller for the iterative multiply/divide datapath.
// It turns a one-cycle multiply or divide start pulse into the load, step and
// correction enables, counts the iterations and flags completion and
// divide-by-zero. It performs no arithmetic of its own.
//
// Ports
//   clk            rising-edge clock
//   clr            asynchronous active-high reset
//   ctrl_mult      start multiply (wins over ctrl_div when both are high)
//   ctrl_div       start divide
//   divisor_zero   datapath flag, divisor register is zero (used in LOAD only)
//   dp_load        load operand/product registers
//   dp_step        perform one datapath iteration
//   dp_fix         divide correction/sign-fix cycle
//   dp_is_div      datapath mode select, 1 = divide (LOAD through DONE)
//   busy           operation in progress (LOAD, STEP, FIX)
//   data_ready     one-cycle completion pulse
//   data_exception divide-by-zero, qualified by data_ready
//   count          iterations completed in the current operation
module multdiv_ctrl #(
    parameter int unsigned ITER  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic             divisor_zero,
    output logic             dp_load,
    output logic             dp_step,
    output logic             dp_fix,
    output logic             dp_is_div,
    output logic             busy,
    output logic             data_ready,
    output logic             data_exception,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_STEP = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ITER);

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             is_div_q;
    logic             exc_q;
    logic             start;

    // Any start pulse aborts whatever is in flight and re-enters LOAD.
    assign start = ctrl_mult | ctrl_div;

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: begin
                if (start) nxt = S_LOAD;
            end
            S_LOAD: begin
                if (start)                         nxt = S_LOAD;
                else if (is_div_q && divisor_zero) nxt = S_DONE;
                else                               nxt = S_STEP;
            end
            S_STEP: begin
                if (start)                    nxt = S_LOAD;
                else if (count_q == CNT_LAST) nxt = is_div_q ? S_FIX : S_DONE;
            end
            S_FIX: begin
                nxt = start ? S_LOAD : S_DONE;
            end
            S_DONE: begin
                nxt = start ? S_LOAD : S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Output decode: pure function of registered state and flags
    always_comb begin
        dp_load        = 1'b0;
        dp_step        = 1'b0;
        dp_fix         = 1'b0;
        dp_is_div      = 1'b0;
        busy           = 1'b0;
        data_ready     = 1'b0;
        data_exception = 1'b0;
        case (state)
            S_LOAD: begin
                dp_load   = 1'b1;
                dp_is_div = is_div_q;
                busy      = 1'b1;
            end
            S_STEP: begin
                dp_step   = 1'b1;
                dp_is_div = is_div_q;
                busy      = 1'b1;
            end
            S_FIX: begin
                dp_fix    = 1'b1;
                dp_is_div = is_div_q;
                busy      = 1'b1;
            end
            S_DONE: begin
                dp_is_div      = is_div_q;
                data_ready     = 1'b1;
                data_exception = exc_q;
            end
            default: ;
        endcase
    end

    // Iteration counter: cleared on entry to LOAD or IDLE, counts only on
    // non-aborted STEP edges and saturates at ITER.
    always_comb begin
        count_d = count_q;
        if (nxt == S_LOAD || nxt == S_IDLE) begin
            count_d = '0;
        end else if (state == S_STEP && count_q != CNT_FULL) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Mode and exception flags; multiply wins a simultaneous start.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            is_div_q <= 1'b0;
            exc_q    <= 1'b0;
        end else if (start) begin
            is_div_q <= ctrl_div & ~ctrl_mult;
            exc_q    <= 1'b0;
        end else if (state == S_LOAD) begin
            exc_q    <= is_div_q & divisor_zero;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: a scoreboard of expected completions
// (mode, exception, final count, completion cycle, step/fix cycle counts) is
// filled when a start is driven and drained when data_ready is seen.
module tb_multdiv_ctrl;

    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = 6;

    logic             clk;
    logic             clr;
    logic             ctrl_mult;
    logic             ctrl_div;
    logic             divisor_zero;
    logic             dp_load;
    logic             dp_step;
    logic             dp_fix;
    logic             dp_is_div;
    logic             busy;
    logic             data_ready;
    logic             data_exception;
    logic [CNT_W-1:0] count;

    typedef struct {
        logic        is_div;
        logic        exc;
        int unsigned count;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   steps;
    int   fixes;

    multdiv_ctrl #(.ITER(ITER), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .clr            (clr),
        .ctrl_mult      (ctrl_mult),
        .ctrl_div       (ctrl_div),
        .divisor_zero   (divisor_zero),
        .dp_load        (dp_load),
        .dp_step        (dp_step),
        .dp_fix         (dp_fix),
        .dp_is_div      (dp_is_div),
        .busy           (busy),
        .data_ready     (data_ready),
        .data_exception (data_exception),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({dp_load, dp_step, dp_fix, dp_is_div, busy,
                    data_ready, data_exception, count});
    endfunction

    // Drive a one-cycle start at posedge+1; returns 1 time unit after E0.
    task automatic start_op(input logic m, input logic d, input logic dz);
        exp_t e;
        ctrl_mult    = m;
        ctrl_div     = d;
        divisor_zero = dz;
        e.is_div = d & ~m;
        e.exc    = e.is_div & dz;
        e.count  = e.exc ? 0 : ITER;
        e.cyc    = cyc + 1 + (e.exc ? 1 : (e.is_div ? int'(ITER) + 2 : int'(ITER) + 1));
        sb.push_back(e);
        @(posedge clk);
        #1;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
    endtask

    task automatic wait_count(input int unsigned target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (32'(count) == target) break;
            @(posedge clk);
            #1;
        end
        check("wait_count", 32'(count), target);
    endtask

    task automatic wait_ready(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (data_ready) break;
            @(posedge clk);
            #1;
        end
        check("wait_ready", 32'(data_ready), 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Completion monitor, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (!clr) begin
            if (dp_load) begin
                steps = 0;
                fixes = 0;
            end
            if (dp_step) steps++;
            if (dp_fix)  fixes++;
            check("busy_phase", 32'(busy), 32'(dp_load | dp_step | dp_fix));
            if (data_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_ready", 32'(data_ready), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ready_cycle", 32'(cyc), 32'(e.cyc));
                    check("exception", 32'(data_exception), 32'(e.exc));
                    check("done_count", 32'(count), e.count);
                    check("done_is_div", 32'(dp_is_div), 32'(e.is_div));
                    check("step_cycles", 32'(steps), e.exc ? 32'd0 : 32'(ITER));
                    check("fix_cycles", 32'(fixes), 32'(e.is_div & ~e.exc));
                end
            end else begin
                check("exc_unqualified", 32'(data_exception), 32'd0);
            end
        end
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        steps        = 0;
        fixes        = 0;
        ctrl_mult    = 1'b0;
        ctrl_div     = 1'b0;
        divisor_zero = 1'b0;
        clr          = 1'b0;
        #2 clr = 1'b1;
        #1 check("reset_outs", all_outs(), 32'd0);
        #20 clr = 1'b0;
        #1 check("post_reset_outs", all_outs(), 32'd0);

        // Multiply
        @(posedge clk);
        #1;
        start_op(1'b1, 1'b0, 1'b0);
        check("mul_load", 32'(dp_load), 32'd1);
        check("mul_load_mode", 32'(dp_is_div), 32'd0);
        wait_drain(100);

        // Divide, nonzero divisor
        start_op(1'b0, 1'b1, 1'b0);
        check("div_load", 32'(dp_load), 32'd1);
        check("div_load_mode", 32'(dp_is_div), 32'd1);
        wait_drain(100);

        // Divide by zero
        start_op(1'b0, 1'b1, 1'b1);
        wait_drain(20);
        divisor_zero = 1'b0;

        // Simultaneous starts: multiply wins
        start_op(1'b1, 1'b1, 1'b0);
        check("both_mode", 32'(dp_is_div), 32'd0);
        wait_drain(100);

        // Abort a multiply at count 10 with a divide
        start_op(1'b1, 1'b0, 1'b0);
        wait_count(10, 40);
        void'(sb.pop_back());
        start_op(1'b0, 1'b1, 1'b0);
        check("abort_count", 32'(count), 32'd0);
        check("abort_load", 32'(dp_load), 32'd1);
        wait_drain(100);

        // Asynchronous reset mid-operation, then a start on the first edge
        start_op(1'b1, 1'b0, 1'b0);
        wait_count(17, 40);
        #2 clr = 1'b1;
        #1 check("clr_outs", all_outs(), 32'd0);
        void'(sb.pop_back());
        #1 clr = 1'b0;
        #1 check("clr_release_outs", all_outs(), 32'd0);
        start_op(1'b1, 1'b0, 1'b0);
        check("post_clr_load", 32'(dp_load), 32'd1);
        wait_drain(100);

        // Back-to-back: divide started in the multiply's DONE cycle
        start_op(1'b1, 1'b0, 1'b0);
        wait_ready(60);
        start_op(1'b0, 1'b1, 1'b0);
        check("b2b_ready_once", 32'(data_ready), 32'd0);
        check("b2b_load", 32'(dp_load), 32'd1);
        check("b2b_mode", 32'(dp_is_div), 32'd1);
        wait_drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencing controller for the iterative multiply/divide datapath. It accepts single-cycle multiply or divide start pulses and then drives the operand load, per-iteration step and final correction enables in order. It counts iterations with an internal counter and reports completion and divide-by-zero. It sits between the core's issue logic and the shift/add datapath built from the team's flip-flop and counter primitives, and it owns no arithmetic.

## Interface
- ITER, 32: number of datapath iterations per operation; ≥2.
- CNT_W, 6: width of the iteration counter; must satisfy 2^CNT_W > ITER.

- clk  in  1  rising-edge clock.
- clr  in  1  reset, asynchronous, active-high; clock clk.
- ctrl_mult  in  1  start multiply; sampled every edge.
- ctrl_div  in  1  start divide; sampled every edge.
- divisor_zero  in  1  datapath flag: divisor register == 0; sampled only in LOAD.
- dp_load  out  1  load operand/product registers (LOAD state).
- dp_step  out  1  perform one iteration (STEP state).
- dp_fix  out  1  divide correction/sign-fix cycle (FIX state).
- dp_is_div  out  1  datapath mode select; 1 = divide; held from LOAD through DONE.
- busy  out  1  high in LOAD, STEP, FIX.
- data_ready  out  1  one-cycle completion pulse (DONE state).
- data_exception  out  1  divide-by-zero; valid only while data_ready = 1, else 0.
- count  out  CNT_W  iterations completed in the current operation.

## Operation
- States: IDLE, LOAD, STEP, FIX, DONE. All outputs except count are Moore decodes of the state and two registered flags: is_div and exc.
- Start = ctrl_mult | ctrl_div. If both are high on the same edge, multiply wins and is_div = 0.
- IDLE: start → LOAD and latch is_div. Otherwise stay.
- LOAD: dp_load = 1 and count ← 0.
  - If is_div & divisor_zero: exc ← 1 and go → DONE, skipping STEP.
  - Otherwise: exc ← 0 and go → STEP.
- STEP: dp_step = 1 and count ← count + 1 on each edge.
  - When the edge leaving the cycle with count = ITER−1 occurs: go → FIX if is_div, else → DONE.
- FIX: dp_fix = 1 for exactly one cycle, then → DONE.
- DONE: data_ready = 1 and data_exception = exc, for one cycle, then → IDLE.
- count:
  - Holds its final value (ITER, or 0 on exception) through FIX/DONE.
  - Cleared to 0 on entry to IDLE.
  - Never wraps: it stops at ITER.
- Restart: a start sampled in any state other than IDLE aborts the current operation.
  - Next state is LOAD with the new mode.
  - The aborted operation never produces data_ready.
  - A start in DONE still shows data_ready for that DONE cycle, then goes to LOAD instead of IDLE.
- Reset: clr forces IDLE, count = 0, is_div = 0, exc = 0. Every output reads 0 while clr = 1 and after release.
- Reset mid-operation: the operation is abandoned immediately, with no data_ready pulse. A start on the first edge after clr falls is honoured.

## Timing
- E0 is the edge that samples the start. Completion lands as follows:
  - LOAD: the cycle after E0.
  - STEP: the cycles after E0+1 … E0+ITER.
  - Multiply: data_ready in the cycle after E0+ITER+1 (E0+33 at ITER = 32).
  - Divide: FIX in the cycle after E0+ITER+1; data_ready in the cycle after E0+ITER+2 (E0+34).
  - Divide by zero: data_ready = data_exception = 1 in the cycle after E0+1.
- dp_step is high for exactly ITER consecutive cycles per non-exception operation.
- busy falls on the same edge that raises data_ready.
- No combinational path from any input to any output.
- A start may be accepted on the edge that leaves DONE, giving back-to-back operations.

## Test plan
- Multiply, ITER = 32: pulse ctrl_mult one cycle → dp_load for 1 cycle, dp_step for 32 cycles, data_ready high at E0+33 for one cycle, data_exception = 0, dp_fix never high, count = 32 during DONE.
- Divide with divisor_zero = 0 → 32 steps, dp_fix one cycle at E0+33, data_ready at E0+34, dp_is_div = 1 from LOAD through DONE.
- Divide with divisor_zero = 1 in LOAD → no dp_step, data_ready = data_exception = 1 at E0+1, count = 0.
- Simultaneous ctrl_mult & ctrl_div → multiply sequence. Then ctrl_div while count = 10 → re-LOAD, count restarts at 0, single data_ready at new E0+34.
- Assert clr asynchronously while count = 17 → all outputs 0 before the next edge, no data_ready. Release clr and pulse ctrl_mult → normal completion at E0+33.
- Back-to-back: ctrl_div pulsed in the DONE cycle of a multiply → data_ready shown once, next cycle dp_load = 1 with dp_is_div = 1.
